// File: rtl/onehot_encoder_stream_if.sv
// onehot_encoder_stream_if
// Bundles the stream and status signals of the one-hot-to-binary encoder.
//   input side : in_valid / in_ready / in_onehot
//   output side: out_valid / out_ready / out_idx / out_err
//   status     : clr_err (request), zero_seen, multi_seen, err_count
// The slave modport is the encoder's view; master is the surrounding logic.
interface onehot_encoder_stream_if #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_onehot;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_err;
    logic                 clr_err;
    logic                 zero_seen;
    logic                 multi_seen;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_onehot, out_ready, clr_err,
        input  in_ready, out_valid, out_idx, out_err,
               zero_seen, multi_seen, err_count
    );

    modport slave (
        input  in_valid, in_onehot, out_ready, clr_err,
        output in_ready, out_valid, out_idx, out_err,
               zero_seen, multi_seen, err_count
    );
endinterface

// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream
// Converts a WIDTH-bit one-hot word into its binary index through a one-deep
// registered valid/ready stage (latency 1, one word per cycle). Every accepted
// word is checked for legality; illegal words are flagged on their output beat
// and recorded in sticky flags plus a saturating error counter.
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - asynchronous active-high reset
//   bus - onehot_encoder_stream_if slave modport (stream + status signals)
// WIDTH must be >= 2 and a power of two.
module onehot_encoder_stream #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    onehot_encoder_stream_if.slave    bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    logic                 out_valid_q,  out_valid_d;
    logic [IDX_W-1:0]     out_idx_q,    out_idx_d;
    logic                 out_err_q,    out_err_d;
    logic                 zero_seen_q,  zero_seen_d;
    logic                 multi_seen_q, multi_seen_d;
    logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;

    logic                 accept;
    logic                 is_zero;
    logic                 is_multi;
    logic [WIDTH-1:0]     lower_clear;  // no bit below position gi is set
    logic [WIDTH-1:0]     first_set;    // isolated lowest set bit
    logic [IDX_W-1:0]     enc_idx;

    // ready depends only on registered state and out_ready, never on in_valid
    assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Legality: zero bits set, or clearing the lowest set bit leaves something
    assign is_zero  = ~|bus.in_onehot;
    assign is_multi = |(bus.in_onehot & (bus.in_onehot - WIDTH'(1)));

    // LSB-priority isolation so multi-hot words map to their lowest set bit
    assign lower_clear[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_lower
            assign lower_clear[gi] = lower_clear[gi-1] & ~bus.in_onehot[gi-1];
        end
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_first
            assign first_set[gi] = bus.in_onehot[gi] & lower_clear[gi];
        end
    endgenerate

    // first_set has at most one bit, so OR-ing the indices yields its position
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (first_set[i]) begin
                enc_idx = enc_idx | IDX_W'(i);
            end
        end
    end

    // Output stage: load on accept, drop valid when consumed without refill
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_idx_d   = enc_idx;
            out_err_d   = is_zero | is_multi;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Status: a clear in the same cycle as an illegal accept is applied first,
    // so the new event is still recorded on top of the cleared state.
    always_comb begin
        zero_seen_d  = bus.clr_err ? 1'b0 : zero_seen_q;
        multi_seen_d = bus.clr_err ? 1'b0 : multi_seen_q;
        err_count_d  = bus.clr_err ? '0   : err_count_q;
        if (accept) begin
            if (is_zero) begin
                zero_seen_d = 1'b1;
            end
            if (is_multi) begin
                multi_seen_d = 1'b1;
            end
            if ((is_zero || is_multi) && (err_count_d != ERR_MAX)) begin
                err_count_d = err_count_d + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_err_q    <= 1'b0;
            zero_seen_q  <= 1'b0;
            multi_seen_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_err_q    <= out_err_d;
            zero_seen_q  <= zero_seen_d;
            multi_seen_q <= multi_seen_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_err    = out_err_q;
    assign bus.zero_seen  = zero_seen_q;
    assign bus.multi_seen = multi_seen_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream
// Scoreboard bench: the driver pushes the expected {err, idx} of every word the
// encoder accepts; an independent monitor pops and compares on every output
// beat. Status outputs are checked directly at quiet points.
module tb_onehot_encoder_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    onehot_encoder_stream_if #(.WIDTH(8), .ERR_CNT_W(8)) bus ();
    onehot_encoder_stream #(.WIDTH(8), .ERR_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         passed = 0;
    logic [3:0] sb[$];        // {err, idx}
    bit         rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic logic [7:0] dec3to8(input logic [2:0] code);
        dec3to8 = 8'b1 << code;
    endfunction

    // Monitor: one line per completed output beat
    initial begin
        logic [3:0] exp;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL beat: got idx=%0d err=%0d, required no beat",
                             bus.out_idx, bus.out_err);
                end else begin
                    exp = sb.pop_front();
                    if ({bus.out_err, bus.out_idx} === exp) begin
                        passed++;
                        $display("beat idx=%0d err=%0d ok", bus.out_idx, bus.out_err);
                    end else begin
                        $display("FAIL beat: got idx=%0d err=%0d, required idx=%0d err=%0d",
                                 bus.out_idx, bus.out_err, exp[2:0], exp[3]);
                    end
                end
            end
        end
    end

    // Random backpressure when enabled
    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one word; returns just before the rising edge that accepts it
    task automatic send(input logic [7:0] w, input logic [2:0] ei, input logic ee,
                        input logic clr, input bit gap);
        int n = 0;
        @(negedge clk);
        if (gap) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.in_valid  = 1'b0;
                bus.in_onehot = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.in_valid  = 1'b1;
        bus.in_onehot = w;
        bus.clr_err   = clr;
        forever begin
            #4;
            if (bus.in_ready) begin
                sb.push_back({ee, ei});
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL accept_timeout: word %h not accepted, required acceptance", w);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_onehot = 8'($urandom);
        bus.clr_err   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d beats pending, required 0", sb.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_onehot = 8'h00;
        bus.out_ready = 1'b1;
        bus.clr_err   = 1'b0;

        // Reset state
        #3;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_idx", 32'(bus.out_idx), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        chk("rst_err_count", 32'(bus.err_count), 0);
        chk("rst_flags", 32'({bus.zero_seen, bus.multi_seen}), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Walk of all legal codes, back to back
        for (int k = 0; k < 8; k++) send(8'(1 << k), 3'(k), 1'b0, 1'b0, 1'b0);
        idle();
        drain();
        chk("walk_err_count", 32'(bus.err_count), 0);

        // Backpressure: 8'h10 held while 8'h02 waits
        send(8'h10, 3'd4, 1'b0, 1'b0, 1'b0);
        fork
            send(8'h02, 3'd1, 1'b0, 1'b0, 1'b0);
            begin
                @(negedge clk);
                bus.out_ready = 1'b0;
                repeat (5) begin
                    #3;
                    chk("bp_in_ready", 32'(bus.in_ready), 0);
                    chk("bp_out_idx", 32'(bus.out_idx), 4);
                    chk("bp_out_valid", 32'(bus.out_valid), 1);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Illegal words
        send(8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        send(8'hA4, 3'd2, 1'b1, 1'b0, 1'b0);
        idle();
        drain();
        #3;
        chk("ill_zero_seen", 32'(bus.zero_seen), 1);
        chk("ill_multi_seen", 32'(bus.multi_seen), 1);
        chk("ill_err_count", 32'(bus.err_count), 2);

        // Saturation, then clear together with an illegal accept
        for (int i = 0; i < 300; i++) send(8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
        idle();
        drain();
        #3;
        chk("sat_err_count", 32'(bus.err_count), 255);
        send(8'h06, 3'd1, 1'b1, 1'b1, 1'b0);
        idle();
        #3;
        chk("clr_acc_err_count", 32'(bus.err_count), 1);
        chk("clr_acc_multi_seen", 32'(bus.multi_seen), 1);
        chk("clr_acc_zero_seen", 32'(bus.zero_seen), 0);
        drain();

        // Plain clear without an accept
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        #3;
        chk("clr_err_count", 32'(bus.err_count), 0);
        chk("clr_flags", 32'({bus.zero_seen, bus.multi_seen}), 0);

        // Round trip from the 3-to-8 decoder with random gaps and backpressure
        rand_rdy = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 8; c++)
                send(dec3to8(3'(c)), 3'(c), 1'b0, 1'b0, 1'b1);
        idle();
        rand_rdy = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        drain();
        #3;
        chk("rt_err_count", 32'(bus.err_count), 0);
        chk("rt_flags", 32'({bus.zero_seen, bus.multi_seen}), 0);

        // Asynchronous reset while a result is stalled
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(8'hC0, 3'd6, 1'b1, 1'b0, 1'b0);
        idle();
        #3;
        chk("pre_rst_out_idx", 32'(bus.out_idx), 6);
        chk("pre_rst_err_count", 32'(bus.err_count), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_out_idx", 32'(bus.out_idx), 0);
        chk("arst_err_count", 32'(bus.err_count), 0);
        chk("arst_flags", 32'({bus.zero_seen, bus.multi_seen}), 0);
        chk("arst_in_ready", 32'(bus.in_ready), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_release_in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/onehot_encoder_stream.md
Name: onehot_encoder_stream

Overview:
- Inverse of the team's 3-to-8 one-hot decoder. Converts a WIDTH-bit one-hot word back to its binary index.
- Registered, with a valid/ready handshake on both sides. One-deep output register; sustains one word per cycle.
- Checks every accepted word for legality (exactly one bit set). Flags illegal words per output beat and keeps sticky status plus a saturating error count.
- Sits downstream of one-hot producers (decoder outputs, arbiter grants); returns indices to the binary-domain logic.

Parameters:
- WIDTH, 8, one-hot input width; must be ≥2 and a power of 2.
- IDX_W, $clog2(WIDTH) (3 at default), output index width; derived, not overridden.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_onehot holds a word.
- in_ready  out  1  block can accept a word this cycle.
- in_onehot  in  WIDTH  word to encode.
- out_valid  out  1  out_idx/out_err hold a result.
- out_ready  in  1  consumer takes the result this cycle.
- out_idx  out  IDX_W  encoded index.
- out_err  out  1  the word behind this result was not exactly-one-hot.
- clr_err  in  1  synchronous clear of the status and the error count.
- zero_seen  out  1  sticky: an all-zero word was accepted.
- multi_seen  out  1  sticky: a word with ≥2 bits set was accepted.
- err_count  out  ERR_CNT_W  count of illegal words accepted, saturating.

Behaviour:
- Reset (async assert, clk-synchronous deassert by environment): out_valid=0, out_idx=0, out_err=0, zero_seen=0, multi_seen=0, err_count=0. in_ready=0 while rst is high.
- in_ready = !out_valid | out_ready, combinational, gated by !rst. There is no combinational path from in_valid to in_ready.
- Accept: an input is accepted when in_valid & in_ready at a rising edge. The result appears on the next cycle (latency 1): out_valid=1, with out_idx and out_err registered.
- Output completion: out_ready & out_valid with no accept clears out_valid the next cycle. Completing the output and accepting an input in the same cycle gives back-to-back beats, with out_valid staying 1 and new data loaded.
- Output stability: while out_valid=1 and out_ready=0, out_idx and out_err hold stable and in_ready=0.
- Encoding of an exactly-one-hot word with bit k set: out_idx=k, out_err=0.
- Encoding of an all-zero word: out_idx=0, out_err=1; zero_seen is set.
- Encoding of a multi-hot word: out_idx = index of the lowest set bit (LSB priority), out_err=1; multi_seen is set.
- err_count increments by 1 on each accepted illegal word. At 2^ERR_CNT_W-1 it holds (no wrap).
- in_onehot is ignored when no accept occurs; an X or changing value while in_valid=0 has no effect.
- clr_err=1: zero_seen, multi_seen and err_count are cleared next cycle.
- clr_err together with an illegal accept in the same cycle: the clear happens first, then the new event is recorded. Result: err_count=1, and the matching sticky flag is set.
- clr_err does not affect out_valid, out_idx, out_err or the handshake.
- Reset mid-transfer: the pending output is discarded (out_valid→0 immediately). All status is lost.

Test Plan:
- Walk k=0..7: in_onehot=1<<k with out_ready=1 throughout → out_idx=k and out_err=0, one cycle after each accept. Eight beats in eight cycles; err_count stays 0.
- Backpressure: accept 8'h10, hold out_ready=0 for 5 cycles while in_valid=1 with 8'h02 → out_idx holds 4 and in_ready=0. Release out_ready → 8'h02 is accepted that cycle; out_idx=1 on the following cycle, with no beat lost or duplicated.
- Illegal words: 8'h00 → idx 0, out_err=1, zero_seen=1. Then 8'hA4 → idx 2, out_err=1, multi_seen=1. Result: err_count=2.
- Saturation (ERR_CNT_W=8): 300 accepted 8'h00 words → err_count=255. Then clr_err together with an illegal accept → err_count=1 and flags reflect only the new word.
- Async reset: assert rst mid-cycle while out_valid=1 → out_valid, out_idx, err_count and the flags go to 0 before the next clk edge, and in_ready=0 while rst is high.
- Round trip: the existing 3-to-8 decoder output drives in_onehot for all 8 codes, random in_valid/out_ready → out_idx equals the original code in order, out_err never set.
